// File: rtl/pr_hrav_pkg.sv
// pr_hrav_pkg: shared sequencer state encoding and error codes
package pr_hrav_pkg;
  typedef enum logic [2:0] {IDLE, QUIESCE, ICAP, DRAIN, SETTLE, FAIL} pr_state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_QTO  = 2'd1;
  localparam logic [1:0] ERR_ITO  = 2'd2;
  localparam logic [1:0] ERR_ICAP = 2'd3;
endpackage

// File: rtl/pr_hrav_pkt_boundary.sv
// pr_hrav_pkt_boundary: tracks whether the snooped AXI-Stream is inside a packet
module pr_hrav_pkt_boundary (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic s_axis_tvalid,
  input  logic s_axis_tready,
  input  logic s_axis_tlast,
  output logic mid_pkt
);
  always_ff @(posedge ACLK)
    if (!ARESETN) mid_pkt <= 1'b0;
    else if (s_axis_tvalid && s_axis_tready) mid_pkt <= !s_axis_tlast;
endmodule

// File: rtl/pr_hrav_pr_sequencer.sv
// pr_hrav_pr_sequencer: partial-reconfiguration sequencer; define PR_HRAV_PR_SEQ_STATS_EN for stat_ok_cnt/stat_err_cnt
module pr_hrav_pr_sequencer
  import pr_hrav_pkg::*;
#(
  parameter int unsigned C_TIMEOUT_W = 24,
  parameter logic [C_TIMEOUT_W-1:0] C_TIMEOUT = {C_TIMEOUT_W{1'b1}},
  parameter int unsigned C_SETTLE_CYCLES = 16
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       cfg_req_valid,
  input  logic       cfg_req_core,
  output logic       cfg_req_ready,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       core0_busy,
  input  logic       core1_busy,
  input  logic       icap_done,
  input  logic       icap_error,
  output logic       core_0_enb,
  output logic       core_1_enb,
  output logic       icap_sel,
  output logic       sts_busy,
  output logic       sts_done,
  output logic       sts_err,
  output logic [1:0] sts_err_code
`ifdef PR_HRAV_PR_SEQ_STATS_EN
  ,
  output logic [15:0] stat_ok_cnt,
  output logic [15:0] stat_err_cnt
`endif
);
  localparam int unsigned CW = $clog2(C_SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(C_SETTLE_CYCLES - 1);
  pr_state_t state, state_n;
  logic ready_n, sel_n, busy_n, done_n, err_n;
  logic tgt, tgt_n, pend, pend_n, mid_pkt, boundary, tgt_busy, to_hit;
  logic [1:0] enb, enb_n, code_n;
  logic [C_TIMEOUT_W-1:0] wd, wd_n, wd_inc;
  logic [CW-1:0] cnt, cnt_n;
  pr_hrav_pkt_boundary u_pkt (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .mid_pkt(mid_pkt)
  );
  assign boundary = !mid_pkt && !(s_axis_tvalid && s_axis_tready);
  assign tgt_busy = tgt ? core1_busy : core0_busy;
  assign wd_inc = &wd ? wd : wd + 1'b1;
  assign to_hit = wd_inc == C_TIMEOUT;
  assign core_0_enb = enb[0];
  assign core_1_enb = enb[1];
  always_comb begin
    state_n = state;
    ready_n = cfg_req_ready;
    sel_n   = icap_sel;
    busy_n  = sts_busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    code_n  = sts_err_code;
    enb_n   = enb;
    tgt_n   = tgt;
    pend_n  = pend;
    wd_n    = wd;
    cnt_n   = cnt;
    case (state)
      IDLE:
        if (pend) begin
          enb_n[tgt] = 1'b0;
          busy_n = 1'b1;
          pend_n = 1'b0;
          state_n = QUIESCE;
        end else if (cfg_req_valid && cfg_req_ready) begin
          ready_n = 1'b0;
          pend_n = 1'b1;
          tgt_n = cfg_req_core;
          code_n = ERR_NONE;
          wd_n = '0;
        end
      QUIESCE:
        if (boundary && !tgt_busy) begin
          sel_n = 1'b1;
          wd_n = '0;
          state_n = ICAP;
        end else if (to_hit) begin
          code_n = ERR_QTO;
          enb_n[tgt] = 1'b1;
          state_n = FAIL;
        end else wd_n = wd_inc;
      ICAP:
        if (icap_error) begin
          code_n = ERR_ICAP;
          state_n = FAIL;
        end else if (icap_done) begin
          cnt_n = '0;
          state_n = DRAIN;
        end else if (to_hit) begin
          code_n = ERR_ITO;
          state_n = FAIL;
        end else wd_n = wd_inc;
      // one dwell cycle lets the ICAP absorb its final word before the steer flips
      DRAIN:
        if (cnt == '0) cnt_n = CW'(1);
        else if (boundary) begin
          sel_n = 1'b0;
          cnt_n = '0;
          state_n = SETTLE;
        end
      SETTLE:
        if (cnt == SETTLE_LAST) begin
          enb_n[tgt] = 1'b1;
          done_n = 1'b1;
          ready_n = 1'b1;
          busy_n = 1'b0;
          state_n = IDLE;
        end else cnt_n = cnt + 1'b1;
      FAIL:
        if (boundary) begin
          sel_n = 1'b0;
          err_n = 1'b1;
          ready_n = 1'b1;
          busy_n = 1'b0;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      state <= IDLE;
      cfg_req_ready <= 1'b1;
      icap_sel <= 1'b0;
      sts_busy <= 1'b0;
      sts_done <= 1'b0;
      sts_err <= 1'b0;
      sts_err_code <= ERR_NONE;
      enb <= 2'b11;
      tgt <= 1'b0;
      pend <= 1'b0;
      wd <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      cfg_req_ready <= ready_n;
      icap_sel <= sel_n;
      sts_busy <= busy_n;
      sts_done <= done_n;
      sts_err <= err_n;
      sts_err_code <= code_n;
      enb <= enb_n;
      tgt <= tgt_n;
      pend <= pend_n;
      wd <= wd_n;
      cnt <= cnt_n;
    end
`ifdef PR_HRAV_PR_SEQ_STATS_EN
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      stat_ok_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      stat_ok_cnt <= stat_ok_cnt + 16'(sts_done);
      stat_err_cnt <= stat_err_cnt + 16'(sts_err);
    end
`endif
endmodule

// File: tb/tb_pr_hrav_pr_sequencer.sv
// tb_pr_hrav_pr_sequencer: directed checks of the PR sequencer (C_TIMEOUT=100, C_SETTLE_CYCLES=16)
module tb_pr_hrav_pr_sequencer;
  logic ACLK, ARESETN, cfg_req_valid, cfg_req_core, cfg_req_ready;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast, core0_busy, core1_busy;
  logic icap_done, icap_error, core_0_enb, core_1_enb, icap_sel;
  logic sts_busy, sts_done, sts_err;
  logic [1:0] sts_err_code;
  int n_vec = 0, n_bad = 0;
`ifdef PR_HRAV_PR_SEQ_STATS_EN
  logic [15:0] stat_ok_cnt, stat_err_cnt;
`endif
  pr_hrav_pr_sequencer #(.C_TIMEOUT_W(24), .C_TIMEOUT(24'd100), .C_SETTLE_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cfg_req_valid(cfg_req_valid), .cfg_req_core(cfg_req_core), .cfg_req_ready(cfg_req_ready),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .core0_busy(core0_busy), .core1_busy(core1_busy),
    .icap_done(icap_done), .icap_error(icap_error),
    .core_0_enb(core_0_enb), .core_1_enb(core_1_enb), .icap_sel(icap_sel),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err), .sts_err_code(sts_err_code)
`ifdef PR_HRAV_PR_SEQ_STATS_EN
    , .stat_ok_cnt(stat_ok_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic request(input logic c);
    cfg_req_valid = 1'b1;
    cfg_req_core = c;
    step();
    cfg_req_valid = 1'b0;
  endtask
  task automatic pulse_done();
    icap_done = 1'b1;
    step();
    icap_done = 1'b0;
  endtask
  task automatic wait_sel(input string tag);
    for (int i = 0; i < 300 && !icap_sel; i++) step();
    check(tag, icap_sel, 1);
  endtask
  task automatic run_to_end(input string tag, input logic exp_done);
    for (int i = 0; i < 300 && !(sts_done || sts_err); i++) step();
    check({tag, "_done"}, sts_done, exp_done);
    check({tag, "_err"}, sts_err, !exp_done);
    check({tag, "_sel"}, icap_sel, 0);
  endtask
  task automatic seq_ok(input logic c, input string tag);
    request(c);
    wait_sel({tag, "_wsel"});
    pulse_done();
    run_to_end(tag, 1'b1);
  endtask
  initial begin
    ARESETN = 1'b0; cfg_req_valid = 1'b0; cfg_req_core = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tlast = 1'b0;
    core0_busy = 1'b0; core1_busy = 1'b0; icap_done = 1'b0; icap_error = 1'b0;
    step(); step();
    check("rst_ready", cfg_req_ready, 1);
    check("rst_enb", {core_1_enb, core_0_enb}, 2'b11);
    check("rst_sel", icap_sel, 0);
    check("rst_sts", {sts_busy, sts_done, sts_err}, 3'b000);
    check("rst_code", sts_err_code, 0);
    ARESETN = 1'b1;
    // idle stream, core 1, done at T+5
    request(1'b1);
    check("t1_ready_T", cfg_req_ready, 0);
    check("t1_enb1_T", core_1_enb, 1);
    step();
    check("t1_enb1_T1", core_1_enb, 0);
    check("t1_busy_T1", sts_busy, 1);
    check("t1_sel_T1", icap_sel, 0);
    step();
    check("t1_sel_T2", icap_sel, 1);
    cfg_req_valid = 1'b1; cfg_req_core = 1'b0;
    step();
    check("t1_ready_busy", cfg_req_ready, 0);
    step();
    cfg_req_valid = 1'b0;
    check("t1_enb0_ignored", core_0_enb, 1);
    pulse_done();
    check("t1_sel_D", icap_sel, 1);
    step();
    check("t1_sel_D1", icap_sel, 1);
    step();
    check("t1_sel_D2", icap_sel, 0);
    for (int i = 8; i < 23; i++) begin
      step();
      check("t1_settle", {sts_done, core_1_enb, core_0_enb}, 3'b001);
    end
    step();
    check("t1_done_T23", {sts_done, core_1_enb, core_0_enb}, 3'b111);
    check("t1_idle_T23", {cfg_req_ready, sts_busy}, 2'b10);
    step();
    check("t1_done_pulse", sts_done, 0);
    // request inside an 8-beat packet
    s_axis_tvalid = 1'b1; s_axis_tready = 1'b1; s_axis_tlast = 1'b0;
    step();
    request(1'b0);
    check("t2_ready", cfg_req_ready, 0);
    for (int i = 3; i < 8; i++) begin
      step();
      check("t2_sel_mid", icap_sel, 0);
    end
    check("t2_enb0", core_0_enb, 0);
    s_axis_tlast = 1'b1;
    step();
    check("t2_sel_last", icap_sel, 0);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    step();
    check("t2_sel_after", icap_sel, 1);
    pulse_done();
    run_to_end("t2", 1'b1);
    // busy core delays quiesce; icap_done lands on the ICAP timeout edge
    core0_busy = 1'b1;
    request(1'b0);
    for (int i = 1; i < 20; i++) begin
      step();
      check("t2b_hold", icap_sel, 0);
    end
    core0_busy = 1'b0;
    step();
    check("t2b_sel", icap_sel, 1);
    for (int i = 1; i < 100; i++) step();
    check("t2b_pre_to", {sts_err, icap_sel}, 2'b01);
    pulse_done();
    check("t2b_code", sts_err_code, 0);
    run_to_end("t2b", 1'b1);
    check("t2b_enb0", core_0_enb, 1);
    // quiesce timeout with core 0 stuck busy
    core0_busy = 1'b1;
    request(1'b0);
    step();
    check("t3_enb0_low", core_0_enb, 0);
    for (int i = 2; i < 101; i++) begin
      step();
      check("t3_wait", {sts_err, icap_sel}, 2'b00);
    end
    step();
    check("t3_code", sts_err_code, 1);
    check("t3_enb0_back", core_0_enb, 1);
    check("t3_err_pre", sts_err, 0);
    step();
    check("t3_err", sts_err, 1);
    check("t3_idle", {cfg_req_ready, sts_busy, icap_sel}, 3'b100);
    step();
    check("t3_err_pulse", sts_err, 0);
    check("t3_code_held", sts_err_code, 1);
    core0_busy = 1'b0;
    // icap_error together with icap_done on core 1
    request(1'b1);
    check("t4_code_clr", sts_err_code, 0);
    step(); step();
    check("t4_sel", icap_sel, 1);
    icap_error = 1'b1; icap_done = 1'b1;
    step();
    icap_error = 1'b0; icap_done = 1'b0;
    check("t4_code", sts_err_code, 3);
    check("t4_sel_fail", {sts_err, icap_sel}, 2'b01);
    step();
    check("t4_err", {sts_err, icap_sel, cfg_req_ready}, 3'b101);
    check("t4_enb1_off", {core_1_enb, core_0_enb}, 2'b01);
    // ICAP timeout on the still-disabled core 1
    request(1'b1);
    wait_sel("t5_wsel");
    run_to_end("t5", 1'b0);
    check("t5_code", sts_err_code, 2);
    check("t5_enb1_off", core_1_enb, 0);
    // already-disabled core reconfigures normally
    seq_ok(1'b1, "t6");
    check("t6_enb1_on", core_1_enb, 1);
    check("t6_code", sts_err_code, 0);
    // reset during ICAP with a packet in progress
    request(1'b0);
    wait_sel("t7_wsel");
    s_axis_tvalid = 1'b1; s_axis_tready = 1'b1; s_axis_tlast = 1'b0;
    step();
    ARESETN = 1'b0;
    step();
    check("t7_rst_enb", {core_1_enb, core_0_enb}, 2'b11);
    check("t7_rst_sel", icap_sel, 0);
    check("t7_rst_ready", {cfg_req_ready, sts_busy}, 2'b10);
    ARESETN = 1'b1; s_axis_tvalid = 1'b0;
    request(1'b0);
    check("t7_accept", cfg_req_ready, 0);
    step();
    check("t7_run", {sts_busy, core_0_enb}, 2'b10);
    wait_sel("t7_wsel2");
    pulse_done();
    run_to_end("t7", 1'b1);
    seq_ok(1'b0, "t8");
    step();
`ifdef PR_HRAV_PR_SEQ_STATS_EN
    check("t8_stat_ok", stat_ok_cnt, 2);
    check("t8_stat_err", stat_err_cnt, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
